alu_seq: RTL and testbench

Parametrised, clocked successor to the 8-bit combinational add/sub ALU of the 8b computer.
- Supports WIDTH-bit operands and eight operations.
- Registers the result and a flags register (Z, C, N) that is written under a flags-in control.
- Adds an iterative shift-add multiplier with a start/busy/done handshake.
- Sits between the A/B registers and the bus driver; the control unit pulses start and waits for done.

---
 rtl/alu_seq.sv | 164 ++++++++++++++++
 tb/tb_alu_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: clocked WIDTH-bit ALU with registered result and Z/C/N flags.
// The iterative shift-add multiplier is present only when ALU_MUL_EN is defined.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   start        one-cycle request; ignored while busy
//   op, fi, a, b operation, flags-in enable and operands, sampled with start
//   data_out     result register; changes only on done cycles or reset
//   busy         multiply in progress
//   done         one-cycle pulse when data_out (and flags if fi) were written
//   zero, carry, negative  flag registers
//
// Op codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
// Without ALU_MUL_EN, op 111 finishes in one cycle with R=0, C=0.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             fi,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry,
  output logic             negative
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Single-cycle datapath, packed as {C, R}.
  logic [WIDTH:0] alu_res;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = {1'b0, a} + {1'b0, b};
      // Top bit of the WIDTH+1 difference is the borrow (a < b unsigned).
      OP_SUB:  alu_res = {1'b0, a} - {1'b0, b};
      OP_AND:  alu_res = {1'b0, a & b};
      OP_OR:   alu_res = {1'b0, a | b};
      OP_XOR:  alu_res = {1'b0, a ^ b};
      // {a, 0} is exactly {shifted-out MSB, a << 1}.
      OP_SHL:  alu_res = {a, 1'b0};
      OP_SHR:  alu_res = {a[0], 1'b0, a[WIDTH-1:1]};
      default: alu_res = '0;
    endcase
  end

  // Completion path shared by single-cycle ops and the multiplier.
  logic             fin_wr;
  logic [WIDTH-1:0] fin_r;
  logic             fin_c;
  logic             fin_fi;

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic               fi_q;
  logic               mul_go;

  assign mul_go = (state == S_IDLE) && start && (op == OP_MUL);
  assign busy   = (state == S_MUL);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fin_wr    = 1'b0;
    fin_r     = alu_res[WIDTH-1:0];
    fin_c     = alu_res[WIDTH];
    fin_fi    = fi;
    case (state)
      S_IDLE: begin
        if (mul_go)     state_nxt = S_MUL;
        else if (start) fin_wr = 1'b1;
      end
      S_MUL: begin
        // Counter at zero means all WIDTH partial products are in acc.
        if (cnt == '0) begin
          state_nxt = S_IDLE;
          fin_wr    = 1'b1;
          fin_r     = acc[WIDTH-1:0];
          fin_c     = |acc[2*WIDTH-1:WIDTH];
          fin_fi    = fi_q;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      fi_q  <= 1'b0;
    end else if (mul_go) begin
      cnt   <= CNT_W'(WIDTH);
      acc   <= '0;
      mcand <= {{WIDTH{1'b0}}, a};
      mplr  <= b;
      fi_q  <= fi;
    end else if (state == S_MUL && cnt != '0) begin
      if (mplr[0]) acc <= acc + mcand;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt - 1'b1;
    end
  end
`else
  assign busy = 1'b0;

  always_comb begin
    fin_wr = start;
    fin_r  = alu_res[WIDTH-1:0];
    fin_c  = alu_res[WIDTH];
    fin_fi = fi;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      done     <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      negative <= 1'b0;
    end else begin
      done <= fin_wr;
      if (fin_wr) begin
        data_out <= fin_r;
        if (fin_fi) begin
          zero     <= (fin_r == '0);
          carry    <= fin_c;
          negative <= fin_r[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=8): directed literal checks plus randomized
// traffic compared every cycle against a latency/arithmetic model.
module tb_alu_seq;
  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic         fi = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] data_out;
  logic         busy, done, zero, carry, negative;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .fi(fi), .a(a), .b(b),
    .data_out(data_out), .busy(busy), .done(done),
    .zero(zero), .carry(carry), .negative(negative)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model state
  bit           m_ok = 1'b0;
  logic [W-1:0] m_data;
  bit           m_busy, m_done, m_z, m_c, m_n;
  int           m_left;
  logic [W-1:0] m_pr;
  bit           m_pc, m_pfi;

  // Returns {C, R} from plain integer arithmetic.
  function automatic logic [W:0] ref_op(input logic [2:0] o, input int unsigned x, input int unsigned y);
    int unsigned r, c, p;
    r = 0; c = 0;
    case (o)
      3'd0: begin p = x + y; r = p % 256; c = (p >= 256); end
      3'd1: begin r = (x + 256 - y) % 256; c = (x < y); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin r = (x * 2) % 256; c = (x >= 128); end
      3'd6: begin r = x / 2; c = x % 2; end
      default: begin
        if (MUL_EN) begin p = x * y; r = p % 256; c = (p >= 256); end
      end
    endcase
    return {c[0], r[W-1:0]};
  endfunction

  task automatic m_apply(input logic [W-1:0] r, input bit c, input bit f);
    m_data = r;
    m_done = 1'b1;
    if (f) begin
      m_z = (r == 0);
      m_c = c;
      m_n = r[W-1];
    end
  endtask

  always @(posedge clk) begin
    logic [W:0] res;
    if (reset) begin
      m_ok = 1'b1; m_data = '0; m_busy = 0; m_done = 0;
      m_z = 0; m_c = 0; m_n = 0; m_left = 0;
    end else if (m_ok) begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_apply(m_pr, m_pc, m_pfi);
          m_busy = 1'b0;
        end
      end else if (start) begin
        res = ref_op(op, a, b);
        if (MUL_EN && op == 3'd7) begin
          m_left = W + 1; m_busy = 1'b1;
          m_pr = res[W-1:0]; m_pc = res[W]; m_pfi = fi;
        end else begin
          m_apply(res[W-1:0], res[W], fi);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Packed as {data, busy, done, z, c, n}.
  always @(negedge clk) begin
    if (m_ok)
      chk("cycle", {19'd0, data_out, busy, done, zero, carry, negative},
          {19'd0, m_data, m_busy, m_done, m_z, m_c, m_n});
  end

  task automatic expect_out(input string name, input logic [W-1:0] d, input bit bz,
                            input bit dn, input bit z, input bit c, input bit n);
    chk(name, {19'd0, data_out, busy, done, zero, carry, negative},
        {19'd0, d, bz, dn, z, c, n});
  endtask

  task automatic step(input bit s, input logic [2:0] o, input bit f,
                      input logic [W-1:0] x, input logic [W-1:0] y);
    start = s; op = o; fi = f; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    step(0, 0, 0, 0, 0);
    step(1, 3'd0, 1, 8'd1, 8'd1);
    expect_out("reset", 8'h00, 0, 0, 0, 0, 0);
    reset = 1'b0;

    step(1, 3'd0, 1, 8'd200, 8'd100);
    expect_out("add_ovf", 8'd44, 0, 1, 0, 1, 0);
    chk("add_model", {24'd0, m_data}, 32'd44);
    step(0, 0, 0, 0, 0);
    expect_out("done_drop", 8'd44, 0, 0, 0, 1, 0);

    step(1, 3'd1, 1, 8'd5, 8'd5);
    expect_out("sub_eq", 8'h00, 0, 1, 1, 0, 0);
    step(1, 3'd1, 1, 8'd3, 8'd5);
    expect_out("sub_borrow", 8'hFE, 0, 1, 0, 1, 1);
    step(1, 3'd2, 0, 8'hF0, 8'h0F);
    expect_out("and_nofi", 8'h00, 0, 1, 0, 1, 1);
    step(1, 3'd5, 1, 8'h81, 8'h00);
    expect_out("shl", 8'h02, 0, 1, 0, 1, 0);
    step(1, 3'd6, 1, 8'h01, 8'h00);
    expect_out("shr", 8'h00, 0, 1, 1, 1, 0);
    chk("shr_model", {29'd0, m_z, m_c, m_n}, 32'b110);

    if (MUL_EN) begin
      step(1, 3'd7, 1, 8'd12, 8'd11);
      expect_out("mul_c0", 8'h00, 1, 0, 1, 1, 0);
      for (int k = 1; k <= W; k++) begin
        // An ADD request mid-multiply must be dropped.
        if (k == 2) step(1, 3'd0, 1, 8'd1, 8'd1);
        else        step(0, 0, 0, 0, 0);
        expect_out("mul_busy", 8'h00, 1, 0, 1, 1, 0);
      end
      step(0, 0, 0, 0, 0);
      expect_out("mul_done", 8'h84, 0, 1, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      expect_out("mul_after", 8'h84, 0, 0, 0, 0, 1);

      step(1, 3'd7, 1, 8'd16, 8'd16);
      for (int k = 1; k <= W + 1; k++) step(0, 0, 0, 0, 0);
      expect_out("mul_ovf", 8'h00, 0, 1, 1, 1, 0);

      step(1, 3'd7, 1, 8'd16, 8'd16);
      for (int k = 1; k <= 3; k++) step(0, 0, 0, 0, 0);
      reset = 1'b1;
      step(0, 0, 0, 0, 0);
      expect_out("mul_abort", 8'h00, 0, 0, 0, 0, 0);
      reset = 1'b0;
      for (int k = 0; k < W + 2; k++) begin
        step(0, 0, 0, 0, 0);
        expect_out("no_ghost_done", 8'h00, 0, 0, 0, 0, 0);
      end
      step(1, 3'd0, 1, 8'd1, 8'd2);
      expect_out("add_after_abort", 8'h03, 0, 1, 0, 0, 0);
    end else begin
      step(1, 3'd7, 1, 8'd3, 8'd3);
      expect_out("mul_off", 8'h00, 0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      expect_out("mul_off_after", 8'h00, 0, 0, 1, 0, 0);
    end

    // Random traffic: frequent starts (many while busy), rare resets.
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom_range(0, 1),
           W'($urandom), W'($urandom));
    end
    reset = 1'b0;
    for (int i = 0; i < W + 3; i++) step(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
